// File: rtl/rinse_spin_ctrl.sv
// Rinse/spin stage controller: drain, refill, rinse-agitate, drain, spin-dry, done.
// Sensor timeouts trap in FAULT; spin pauses while the lid is open.
module rinse_spin_ctrl #(
   parameter int CNT_W         = 12,
   parameter int RINSE_TICKS   = 300,
   parameter int REV_PERIOD    = 100,
   parameter int SPIN_TICKS    = 600,
   parameter int FILL_TIMEOUT  = 500,
   parameter int DRAIN_TIMEOUT = 500
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       T2d,
   input  logic       WaterFull,
   input  logic       WaterEmpty,
   input  logic       LidClosed,
   output logic       FillValve,
   output logic       DrainValve,
   output logic [3:0] InputMotor,
   output logic       MotorEn,
   output logic       Done,
   output logic       Fault,
   output logic [2:0] State
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRAIN1 = 3'd1,
      FILL   = 3'd2,
      RINSE  = 3'd3,
      DRAIN2 = 3'd4,
      SPIN   = 3'd5,
      DONE   = 3'd6,
      FAULT  = 3'd7
   } state_t;

   localparam logic [CNT_W-1:0] RINSE_LAST = CNT_W'(RINSE_TICKS - 1);
   localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_TICKS - 1);
   localparam logic [CNT_W-1:0] SPIN_HALF  = CNT_W'(SPIN_TICKS / 2);
   localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] REV_P      = CNT_W'(REV_PERIOD);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [3:0]       motor_q, motor_d;
   logic             fill_q, fill_d;
   logic             drain_q, drain_d;
   logic             en_q, en_d;
   logic             done_q, done_d;
   logic             fault_q, fault_d;
   logic             spin_pause;
   logic             motor_ok;
   logic [3:0]       motor_base;
   logic [CNT_W-1:0] rev_quot;

   // Forward rotates 1->8->4->2->1, reverse rotates 1->2->4->8->1.
   function automatic logic [3:0] step_fwd(input logic [3:0] p);
      return {p[0], p[3:1]};
   endfunction

   function automatic logic [3:0] step_rev(input logic [3:0] p);
      return {p[2:0], p[3]};
   endfunction

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q + 1'b1;
      spin_pause = (state_q == SPIN) && !LidClosed;

      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (T2d) state_d = DRAIN1;
         end
         DRAIN1: begin
            if (WaterEmpty)                 state_d = FILL;
            else if (timer_q == DRAIN_LAST) state_d = FAULT;
         end
         FILL: begin
            if (WaterFull)                 state_d = RINSE;
            else if (timer_q == FILL_LAST) state_d = FAULT;
         end
         RINSE: begin
            if (timer_q == RINSE_LAST) state_d = DRAIN2;
         end
         DRAIN2: begin
            if (WaterEmpty)                 state_d = SPIN;
            else if (timer_q == DRAIN_LAST) state_d = FAULT;
         end
         SPIN: begin
            if (spin_pause)                timer_d = timer_q;
            else if (timer_q == SPIN_LAST) state_d = DONE;
         end
         DONE: begin
            timer_d = '0;
            if (!T2d) state_d = IDLE;
         end
         default: begin
            timer_d = '0;
         end
      endcase

      if (state_d != state_q) timer_d = '0;
   end

   // Outputs are derived from the next state so they change on the same edge as State.
   always_comb begin
      fill_d     = (state_d == FILL);
      drain_d    = (state_d == DRAIN1) || (state_d == DRAIN2) || (state_d == SPIN);
      done_d     = (state_d == DONE);
      fault_d    = (state_d == FAULT);
      motor_ok   = (motor_q == 4'd1) || (motor_q == 4'd2) ||
                   (motor_q == 4'd4) || (motor_q == 4'd8);
      motor_base = motor_ok ? motor_q : 4'd1;
      rev_quot   = timer_d / REV_P;
      motor_d    = 4'd1;
      en_d       = 1'b0;

      if (state_d == RINSE) begin
         en_d    = 1'b1;
         motor_d = rev_quot[0] ? step_rev(motor_base) : step_fwd(motor_base);
      end else if (state_d == SPIN) begin
         if (spin_pause) begin
            motor_d = motor_base;
         end else begin
            en_d    = 1'b1;
            motor_d = (timer_d >= SPIN_HALF || timer_d[0]) ? step_fwd(motor_base)
                                                           : motor_base;
         end
      end

      if (!motor_ok) motor_d = 4'd1;
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= IDLE;
         timer_q <= '0;
         motor_q <= 4'd1;
         fill_q  <= 1'b0;
         drain_q <= 1'b0;
         en_q    <= 1'b0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         motor_q <= motor_d;
         fill_q  <= fill_d;
         drain_q <= drain_d;
         en_q    <= en_d;
         done_q  <= done_d;
         fault_q <= fault_d;
      end
   end

   assign FillValve  = fill_q;
   assign DrainValve = drain_q;
   assign InputMotor = motor_q;
   assign MotorEn    = en_q;
   assign Done       = done_q;
   assign Fault      = fault_q;
   assign State      = state_q;

endmodule

// File: tb/tb_rinse_spin_ctrl.sv
// Directed bench for rinse_spin_ctrl: nominal vector table plus timeout, lid-pause,
// reset and done-hold sequences.
module tb_rinse_spin_ctrl;

   logic       clk = 1'b0;
   logic       rst, t2d, full, empty, lid;
   logic       fill_v, drain_v, en, done, fault;
   logic [3:0] motor;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rinse_spin_ctrl #(
      .CNT_W        (12),
      .RINSE_TICKS  (8),
      .REV_PERIOD   (2),
      .SPIN_TICKS   (8),
      .FILL_TIMEOUT (5),
      .DRAIN_TIMEOUT(6)
   ) dut (
      .CLK       (clk),
      .Reset     (rst),
      .T2d       (t2d),
      .WaterFull (full),
      .WaterEmpty(empty),
      .LidClosed (lid),
      .FillValve (fill_v),
      .DrainValve(drain_v),
      .InputMotor(motor),
      .MotorEn   (en),
      .Done      (done),
      .Fault     (fault),
      .State     (state)
   );

   typedef struct {
      logic       rst, t2d, full, empty, lid;
      logic [2:0] st;
      logic       fill, drain;
      logic [3:0] mot;
      logic       en, dn, flt;
   } vec_t;

   vec_t vecs[29];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int st, input int fl, input int dr,
                          input int mt, input int me, input int dn, input int ft);
      chk({tag, ".state"}, 32'(state), st);
      chk({tag, ".fill"},  32'(fill_v), fl);
      chk({tag, ".drain"}, 32'(drain_v), dr);
      chk({tag, ".motor"}, 32'(motor), mt);
      chk({tag, ".en"},    32'(en), me);
      chk({tag, ".done"},  32'(done), dn);
      chk({tag, ".fault"}, 32'(fault), ft);
   endtask

   task automatic go_reset();
      rst = 1'b1; t2d = 1'b0; full = 1'b0; empty = 1'b0; lid = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      //          rst t2d full empty lid   st fill drain mot en dn flt
      vecs[0]  = '{1, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0, 0};
      vecs[1]  = '{0, 1, 0, 0, 1,  1, 0, 1, 1, 0, 0, 0};
      vecs[2]  = '{0, 1, 0, 0, 1,  1, 0, 1, 1, 0, 0, 0};
      vecs[3]  = '{0, 1, 0, 0, 1,  1, 0, 1, 1, 0, 0, 0};
      vecs[4]  = '{0, 1, 0, 1, 1,  2, 1, 0, 1, 0, 0, 0};
      vecs[5]  = '{0, 1, 0, 1, 1,  2, 1, 0, 1, 0, 0, 0};
      vecs[6]  = '{0, 1, 0, 1, 1,  2, 1, 0, 1, 0, 0, 0};
      vecs[7]  = '{0, 1, 0, 1, 1,  2, 1, 0, 1, 0, 0, 0};
      vecs[8]  = '{0, 1, 1, 1, 1,  3, 0, 0, 8, 1, 0, 0};
      vecs[9]  = '{0, 1, 0, 0, 1,  3, 0, 0, 4, 1, 0, 0};
      vecs[10] = '{0, 1, 0, 0, 1,  3, 0, 0, 8, 1, 0, 0};
      vecs[11] = '{0, 1, 0, 0, 1,  3, 0, 0, 1, 1, 0, 0};
      vecs[12] = '{0, 1, 0, 0, 1,  3, 0, 0, 8, 1, 0, 0};
      vecs[13] = '{0, 1, 0, 0, 1,  3, 0, 0, 4, 1, 0, 0};
      vecs[14] = '{0, 1, 0, 0, 1,  3, 0, 0, 8, 1, 0, 0};
      vecs[15] = '{0, 1, 0, 0, 1,  3, 0, 0, 1, 1, 0, 0};
      vecs[16] = '{0, 1, 0, 0, 1,  4, 0, 1, 1, 0, 0, 0};
      vecs[17] = '{0, 1, 0, 1, 1,  5, 0, 1, 1, 1, 0, 0};
      vecs[18] = '{0, 1, 0, 0, 1,  5, 0, 1, 8, 1, 0, 0};
      vecs[19] = '{0, 1, 0, 0, 1,  5, 0, 1, 8, 1, 0, 0};
      vecs[20] = '{0, 1, 0, 0, 1,  5, 0, 1, 4, 1, 0, 0};
      vecs[21] = '{0, 1, 0, 0, 1,  5, 0, 1, 2, 1, 0, 0};
      vecs[22] = '{0, 1, 0, 0, 1,  5, 0, 1, 1, 1, 0, 0};
      vecs[23] = '{0, 1, 0, 0, 1,  5, 0, 1, 8, 1, 0, 0};
      vecs[24] = '{0, 1, 0, 0, 1,  5, 0, 1, 4, 1, 0, 0};
      vecs[25] = '{0, 1, 0, 0, 1,  6, 0, 0, 1, 0, 1, 0};
      vecs[26] = '{0, 1, 0, 0, 1,  6, 0, 0, 1, 0, 1, 0};
      vecs[27] = '{0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0, 0};
      vecs[28] = '{0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0, 0};

      // Nominal walk through every state.
      for (int i = 0; i < 29; i++) begin
         rst = vecs[i].rst; t2d = vecs[i].t2d; full = vecs[i].full;
         empty = vecs[i].empty; lid = vecs[i].lid;
         tick();
         chk_all($sformatf("nom[%0d]", i), vecs[i].st, vecs[i].fill, vecs[i].drain,
                 vecs[i].mot, vecs[i].en, vecs[i].dn, vecs[i].flt);
      end

      // Fill timeout: five FILL cycles, then a sticky fault until reset.
      go_reset();
      t2d = 1'b1; empty = 1'b1;
      tick();
      chk("fto.drain1", 32'(state), 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("fto.fill[%0d]", i), 32'({state, fill_v}), {3'd2, 1'b1});
      end
      tick();
      chk_all("fto.fault", 7, 0, 0, 1, 0, 0, 1);
      full = 1'b1; lid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk($sformatf("fto.hold[%0d]", i), 32'({state, fault}), {3'd7, 1'b1});
      end
      rst = 1'b1;
      tick();
      chk_all("fto.reset", 0, 0, 0, 1, 0, 0, 0);

      // WaterFull on the timeout cycle wins over the fault.
      go_reset();
      t2d = 1'b1; empty = 1'b1; full = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 4; i++) tick();
      chk("edge.fill_t4", 32'(state), 2);
      full = 1'b1;
      tick();
      chk_all("edge.rinse", 3, 0, 0, 8, 1, 0, 0);

      // Reset mid-RINSE at timer 4, then restart with T2d still high.
      full = 1'b0; empty = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk_all("rr.t4", 3, 0, 0, 8, 1, 0, 0);
      rst = 1'b1;
      tick();
      chk_all("rr.reset", 0, 0, 0, 1, 0, 0, 0);
      rst = 1'b0;
      tick();
      chk_all("rr.drain1", 1, 0, 1, 1, 0, 0, 0);

      // Drain timeout with the tub never reporting empty.
      go_reset();
      t2d = 1'b1; empty = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("dto.t5", 32'(state), 1);
      tick();
      chk_all("dto.fault", 7, 0, 0, 1, 0, 0, 1);

      // Lid opened at SPIN timer 3 for 10 cycles; DONE then lands 18 edges after SPIN entry.
      go_reset();
      t2d = 1'b1; empty = 1'b1; full = 1'b1; lid = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      chk_all("lid.spin0", 5, 0, 1, 1, 1, 0, 0);
      empty = 1'b0; full = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("lid.t3motor", 32'(motor), 4);
      lid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_all($sformatf("lid.pause[%0d]", i), 5, 0, 1, 4, 0, 0, 0);
      end
      lid = 1'b1;
      tick();
      chk_all("lid.resume", 5, 0, 1, 2, 1, 0, 0);
      n = 14;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      chk("lid.done_latency", 32'(n), 18);

      // DONE holds while T2d stays high, releases one edge after it falls.
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_all($sformatf("dn.hold[%0d]", i), 6, 0, 0, 1, 0, 1, 0);
      end
      t2d = 1'b0;
      tick();
      chk_all("dn.release", 0, 0, 0, 1, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
